// File: rtl/bt_uart_scheduler.sv
// bt_uart_scheduler: round-robin TX FIFO arbiter for two packet
// requesters plus a one-byte-at-a-time RX FIFO reader.
module bt_uart_scheduler #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_wrfull,
  output logic             tx_write,
  output logic [7:0]       tx_writedata,
  input  logic             a_valid,
  input  logic [7:0]       a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [7:0]       b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic [1:0]       grant,
  output logic             timeout_err,
  output logic [CNT_W-1:0] tx_count,
  input  logic             rx_rdempty,
  output logic             rx_read,
  input  logic [7:0]       rx_readdata,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  input  logic             rx_ready
);

  localparam int IW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {T_IDLE, T_A, T_B} tx_st_t;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_CAPT, R_HOLD} rx_st_t;

  tx_st_t        tx_st, tx_nxt;
  rx_st_t        rx_st, rx_nxt;
  logic          ptr_b, ptr_nxt;
  logic [IW-1:0] idle_cnt, idle_nxt;
  logic          sel_valid, sel_last;
  logic          xfer, expire;
  logic          win_a, win_b;

  // TX next state, grant mux and idle-timeout bookkeeping
  always_comb begin
    tx_nxt       = tx_st;
    ptr_nxt      = ptr_b;
    idle_nxt     = idle_cnt;
    sel_valid    = 1'b0;
    sel_last     = 1'b0;
    tx_writedata = '0;
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    unique case (tx_st)
      T_A: begin
        sel_valid    = a_valid;
        sel_last     = a_last;
        tx_writedata = a_data;
        a_ready      = ~tx_wrfull;
      end
      T_B: begin
        sel_valid    = b_valid;
        sel_last     = b_last;
        tx_writedata = b_data;
        b_ready      = ~tx_wrfull;
      end
      default: ;
    endcase
    xfer   = sel_valid & ~tx_wrfull;
    expire = (tx_st != T_IDLE) & ~sel_valid
           & (idle_cnt == IDLE_MAX);
    win_a  = a_valid & (~b_valid | ~ptr_b);
    win_b  = b_valid & (~a_valid | ptr_b);
    if (tx_st == T_IDLE) begin
      idle_nxt = '0;
      unique case (1'b1)
        win_a:   tx_nxt = T_A;
        win_b:   tx_nxt = T_B;
        default: ;
      endcase
    end else if (xfer) begin
      idle_nxt = '0;
      if (sel_last) begin
        tx_nxt  = T_IDLE;
        ptr_nxt = (tx_st == T_A);
      end
    end else if (!sel_valid) begin
      if (expire) begin
        tx_nxt   = T_IDLE;
        ptr_nxt  = (tx_st == T_A);
        idle_nxt = '0;
      end else begin
        idle_nxt = idle_cnt + 1'b1;
      end
    end
  end

  assign tx_write    = xfer;
  assign timeout_err = expire;
  assign grant       = {tx_st == T_B, tx_st == T_A};

  // TX state, round-robin pointer, idle counter and byte counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_st    <= T_IDLE;
      ptr_b    <= 1'b0;
      idle_cnt <= '0;
      tx_count <= '0;
    end else begin
      tx_st    <= tx_nxt;
      ptr_b    <= ptr_nxt;
      idle_cnt <= idle_nxt;
      if (xfer) tx_count <= tx_count + 1'b1;
    end
  end

  // RX next state: read, capture, then hold until consumed
  always_comb begin
    rx_nxt = rx_st;
    unique case (rx_st)
      R_IDLE:  if (!rx_rdempty) rx_nxt = R_READ;
      R_READ:  rx_nxt = R_CAPT;
      R_CAPT:  rx_nxt = R_HOLD;
      R_HOLD:  if (rx_ready) rx_nxt = R_IDLE;
      default: rx_nxt = R_IDLE;
    endcase
  end

  // RX state plus registered strobe, valid and data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_st    <= R_IDLE;
      rx_read  <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_st    <= rx_nxt;
      rx_read  <= (rx_nxt == R_READ);
      rx_valid <= (rx_nxt == R_HOLD);
      if (rx_st == R_CAPT) rx_data <= rx_readdata;
    end
  end

endmodule

// File: tb/tb_bt_uart_scheduler.sv
// tb_bt_uart_scheduler: directed bench with requester, TX FIFO
// and RX FIFO models driven cycle by cycle.
module tb_bt_uart_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_wrfull;
  logic        tx_write;
  logic [7:0]  tx_writedata;
  logic        a_valid, a_last, a_ready;
  logic [7:0]  a_data;
  logic        b_valid, b_last, b_ready;
  logic [7:0]  b_data;
  logic [1:0]  grant;
  logic        timeout_err;
  logic [15:0] tx_count;
  logic        rx_rdempty, rx_read;
  logic [7:0]  rx_readdata;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  logic [8:0] aq[$];
  logic [8:0] bq[$];
  logic [7:0] txlog[$];
  logic [7:0] rx_mem [0:3];
  int         rx_n = 0;
  int         rd = 0;
  int         nreads = 0;
  logic       rx_pend = 1'b0;
  logic       full_req = 1'b0;
  logic       rdy_req = 1'b0;

  bt_uart_scheduler #(.TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .tx_wrfull(tx_wrfull),
    .tx_write(tx_write),
    .tx_writedata(tx_writedata),
    .a_valid(a_valid),
    .a_data(a_data),
    .a_last(a_last),
    .a_ready(a_ready),
    .b_valid(b_valid),
    .b_data(b_data),
    .b_last(b_last),
    .b_ready(b_ready),
    .grant(grant),
    .timeout_err(timeout_err),
    .tx_count(tx_count),
    .rx_rdempty(rx_rdempty),
    .rx_read(rx_read),
    .rx_readdata(rx_readdata),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1ns later.
  task automatic cyc();
    @(negedge clk);
    if (rx_pend) begin
      if (rd < rx_n) rx_readdata = rx_mem[rd];
      rd++;
      rx_pend = 1'b0;
    end
    rx_rdempty = (rd >= rx_n);
    rx_ready   = rdy_req;
    tx_wrfull  = full_req;
    a_valid = (aq.size() > 0);
    a_data  = a_valid ? aq[0][7:0] : 8'h00;
    a_last  = a_valid ? aq[0][8] : 1'b0;
    b_valid = (bq.size() > 0);
    b_data  = b_valid ? bq[0][7:0] : 8'h00;
    b_last  = b_valid ? bq[0][8] : 1'b0;
    #1;
    if (tx_write) txlog.push_back(tx_writedata);
    if (a_valid && a_ready) void'(aq.pop_front());
    if (b_valid && b_ready) void'(bq.pop_front());
    if (rx_read) begin
      rx_pend = 1'b1;
      nreads++;
    end
  endtask

  task automatic log_chk(input string tag, input int n,
                         input logic [63:0] exp);
    logic [63:0] p = '0;
    foreach (txlog[i]) p = {p[55:0], txlog[i]};
    chk({tag, "_len"}, 64'(txlog.size()), 64'(n));
    chk(tag, p, exp);
    txlog.delete();
  endtask

  initial begin
    reset = 1'b1;
    tx_wrfull = 1'b0;
    a_valid = 0; a_data = 0; a_last = 0;
    b_valid = 0; b_data = 0; b_last = 0;
    rx_rdempty = 1'b1;
    rx_readdata = 8'h00;
    rx_ready = 1'b0;

    // reset state
    cyc(); cyc();
    chk("rst_grant", grant, 0);
    chk("rst_tx_write", tx_write, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_tx_count", tx_count, 0);
    chk("rst_rx_read", rx_read, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    reset = 1'b0;

    // simultaneous requests, A preferred after reset
    aq = '{9'h041, 9'h042, 9'h143};
    bq = '{9'h061, 9'h062, 9'h163};
    cyc();
    chk("arb_idle_grant", grant, 0);
    cyc();
    chk("arb_grant_a", grant, 2'b01);
    chk("arb_b_ready", b_ready, 0);
    cyc(); cyc(); cyc();
    chk("arb_gap_grant", grant, 0);
    chk("arb_gap_write", tx_write, 0);
    cyc();
    chk("arb_grant_b", grant, 2'b10);
    cyc(); cyc(); cyc();
    log_chk("arb_log", 6, 64'h0000_4142_4361_6263);
    chk("arb_count", tx_count, 6);

    // RX: two bytes, consumer stalls 20 cycles
    rx_mem[0] = 8'h30;
    rx_mem[1] = 8'h31;
    rd = 0;
    nreads = 0;
    rx_n = 2;
    cyc();
    chk("rx_read_c0", rx_read, 0);
    cyc();
    chk("rx_read_c1", rx_read, 1);
    cyc();
    chk("rx_read_c2", rx_read, 0);
    chk("rx_valid_c2", rx_valid, 0);
    cyc();
    chk("rx_valid_c3", rx_valid, 1);
    chk("rx_data_c3", rx_data, 8'h30);
    for (int i = 0; i < 19; i++) begin
      cyc();
      chk("rx_hold_valid", rx_valid, 1);
      chk("rx_hold_data", rx_data, 8'h30);
    end
    chk("rx_one_read", nreads, 1);
    rdy_req = 1'b1;
    cyc();
    rdy_req = 1'b0;
    cyc();
    chk("rx_valid_drop", rx_valid, 0);
    cyc();
    chk("rx_read_2nd", rx_read, 1);
    cyc();
    chk("rx_valid_capt", rx_valid, 0);
    cyc();
    chk("rx_valid_2nd", rx_valid, 1);
    chk("rx_data_2nd", rx_data, 8'h31);
    rdy_req = 1'b1;
    cyc();
    rdy_req = 1'b0;
    cyc();
    chk("rx_valid_end", rx_valid, 0);
    repeat (4) cyc();
    chk("rx_no_overread", nreads, 2);

    // single-byte A packet moves pointer to B
    aq = '{9'h111};
    cyc(); cyc(); cyc();
    chk("one_count", tx_count, 7);
    txlog.delete();

    // reset in the middle of an A packet
    aq = '{9'h050, 9'h051, 9'h052, 9'h053,
           9'h054, 9'h055, 9'h056, 9'h157};
    repeat (7) cyc();
    chk("mid_grant", grant, 2'b01);
    chk("mid_count", tx_count, 12);
    reset = 1'b1;
    #1;
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_write", tx_write, 0);
    chk("mid_rst_a_ready", a_ready, 0);
    chk("mid_rst_count", tx_count, 0);
    chk("mid_rst_rx_data", rx_data, 0);
    aq.delete();
    txlog.delete();
    cyc(); cyc();
    reset = 1'b0;

    // pointer must prefer A again after reset
    aq = '{9'h1AA};
    bq = '{9'h1BB};
    cyc();
    cyc();
    chk("ptr_grant_a", grant, 2'b01);
    chk("ptr_data_a", tx_writedata, 8'hAA);
    cyc();
    cyc();
    chk("ptr_grant_b", grant, 2'b10);
    cyc();
    log_chk("ptr_log", 2, 64'h0000_0000_0000_AABB);

    // A back-to-back packets while B waits
    aq = '{9'h0A1, 9'h1A2, 9'h0A3, 9'h1A4};
    bq = '{9'h0B1, 9'h1B2};
    repeat (10) cyc();
    log_chk("b2b_log", 6, 64'h0000_A1A2_B1B2_A3A4);
    chk("b2b_count", tx_count, 8);

    // FIFO full stall mid-packet
    aq = '{9'h0C1, 9'h0C2, 9'h1C3};
    cyc(); cyc();
    full_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("full_write", tx_write, 0);
      chk("full_a_ready", a_ready, 0);
      chk("full_timeout", timeout_err, 0);
      chk("full_grant", grant, 2'b01);
    end
    full_req = 1'b0;
    cyc();
    chk("full_resume_wr", tx_write, 1);
    chk("full_resume_data", tx_writedata, 8'hC2);
    cyc(); cyc();
    log_chk("full_log", 3, 64'h0000_0000_00C1_C2C3);
    chk("full_count", tx_count, 11);

    // grant revoked after 8 idle cycles, B then served
    aq = '{9'h0D1};
    cyc(); cyc();
    bq = '{9'h1E1};
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("to_quiet", timeout_err, 0);
      chk("to_hold_grant", grant, 2'b01);
      chk("to_b_ready", b_ready, 0);
    end
    cyc();
    chk("to_pulse", timeout_err, 1);
    chk("to_pulse_grant", grant, 2'b01);
    cyc();
    chk("to_revoked", grant, 0);
    chk("to_one_cycle", timeout_err, 0);
    cyc();
    chk("to_grant_b", grant, 2'b10);
    chk("to_data_b", tx_writedata, 8'hE1);
    cyc();
    log_chk("to_log", 2, 64'h0000_0000_0000_D1E1);
    chk("to_count", tx_count, 13);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
